// File: rtl/aes_pkg.sv
// Shared types and constants for AES block assembly: byte/word/state layouts
// and the word-fill FSM encoding.
package aes_pkg;

  localparam int unsigned AES_NW = 4;
  localparam int unsigned AES_NB = 4;
  localparam int unsigned WIDX_W = $clog2(AES_NW);

  typedef logic [7:0]                 byte_t;
  typedef byte_t [AES_NB-1:0]         word_t;
  typedef byte_t [AES_NW*AES_NB-1:0]  state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_CAP
  } fill_state_e;

endpackage

// File: rtl/aes_blk_slot.sv
// One 16-byte AES state buffer with word-indexed write and a full flag.
module aes_blk_slot
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [WIDX_W-1:0] wr_idx_i,
  input  word_t             wr_data_i,
  input  logic              set_full_i,
  input  logic              clr_full_i,
  output logic              full_o,
  output state_t            data_o
);

  state_t data_q;
  logic   full_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        for (int unsigned w = 0; w < AES_NW; w++) begin
          if (wr_idx_i == WIDX_W'(w)) begin
            data_q[w*AES_NB +: AES_NB] <= wr_data_i;
          end
        end
      end
      // Fill and drain never target the same slot in one cycle.
      if (set_full_i) begin
        full_q <= 1'b1;
      end else if (clr_full_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/aes_blk_assembler.sv
// Assembles 4-byte collector words into 16-byte AES state blocks through a
// ping-pong pair of slots, with valid/ready delivery to the AES core.
module aes_blk_assembler
  import aes_pkg::*;
(
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           word_valid,
  output logic                           word_rd,
  input  logic [AES_NB*8-1:0]            word_in,
  output logic                           blk_valid,
  input  logic                           blk_ready,
  output logic [AES_NW*AES_NB*8-1:0]     blk_out,
  output logic [WIDX_W-1:0]              fill_cnt
);

  localparam int unsigned NW = AES_NW;

  fill_state_e       state_q;
  logic              word_rd_q;
  logic [WIDX_W-1:0] fill_cnt_q;
  logic              fill_sel_q;
  logic              out_sel_q;

  logic [1:0]        buf_full;
  state_t            buf_data [2];

  logic              cap_c;
  logic              last_c;
  logic              drain_c;

  assign cap_c   = (state_q == F_CAP) && !flush;
  assign last_c  = (fill_cnt_q == WIDX_W'(NW-1));
  assign drain_c = blk_valid && blk_ready && !flush;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    aes_blk_slot u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .clr_i      (flush),
      .wr_en_i    (cap_c && (fill_sel_q == 1'(s))),
      .wr_idx_i   (fill_cnt_q),
      .wr_data_i  (word_in),
      .set_full_i (cap_c && last_c && (fill_sel_q == 1'(s))),
      .clr_full_i (drain_c && (out_sel_q == 1'(s))),
      .full_o     (buf_full[s]),
      .data_o     (buf_data[s])
    );
  end

  // Fill FSM: request, wait for the collector to register the word, capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= F_IDLE;
      word_rd_q  <= 1'b0;
      fill_cnt_q <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
    end else if (flush) begin
      state_q    <= F_IDLE;
      word_rd_q  <= 1'b0;
      fill_cnt_q <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
    end else begin
      if (drain_c) begin
        out_sel_q <= ~out_sel_q;
      end
      case (state_q)
        F_IDLE: begin
          if (word_valid && !buf_full[fill_sel_q]) begin
            word_rd_q <= 1'b1;
            state_q   <= F_REQ;
          end
        end
        F_REQ: begin
          word_rd_q <= 1'b0;
          state_q   <= F_CAP;
        end
        F_CAP: begin
          state_q <= F_IDLE;
          if (last_c) begin
            fill_cnt_q <= '0;
            fill_sel_q <= ~fill_sel_q;
          end else begin
            fill_cnt_q <= fill_cnt_q + WIDX_W'(1);
          end
        end
        default: begin
          state_q   <= F_IDLE;
          word_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_rd   = word_rd_q;
  assign fill_cnt  = fill_cnt_q;
  assign blk_valid = buf_full[out_sel_q];
  assign blk_out   = buf_data[out_sel_q];

endmodule

// File: tb/tb_aes_blk_assembler.sv
// Directed bench for aes_blk_assembler with a behavioural 1-word collector.
module tb_aes_blk_assembler;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic         word_valid;
  logic         word_rd;
  logic [31:0]  word_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_out;
  logic [1:0]   fill_cnt;

  logic [31:0]  up_q [$];
  int           rd_cnt;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    logic         ready;
    logic         exp_rd;
    logic         exp_bv;
    logic [1:0]   exp_fc;
    logic         chk_blk;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t tbl [13];

  aes_blk_assembler dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .word_valid (word_valid),
    .word_rd    (word_rd),
    .word_in    (word_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_out    (blk_out),
    .fill_cnt   (fill_cnt)
  );

  always #5 clk = ~clk;

  // Collector model: registers a word on rd_en, full flag tracks queue.
  initial begin
    word_in = '0;
    forever begin
      @(posedge clk);
      if (word_rd === 1'b1) begin
        rd_cnt++;
        if (up_q.size() > 0) word_in = up_q.pop_front();
        word_valid = (up_q.size() > 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [31:0] mk_word(input int n, input int k);
    logic [7:0] b;
    b = 8'(n*16 + k*4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [127:0] mk_block(input int n);
    logic [127:0] blk;
    for (int k = 0; k < 4; k++) blk[k*32 +: 32] = mk_word(n, k);
    return blk;
  endfunction

  task automatic push_word(input logic [31:0] w);
    up_q.push_back(w);
    word_valid = 1'b1;
  endtask

  task automatic push_block(input int n);
    for (int k = 0; k < 4; k++) push_word(mk_word(n, k));
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn     = 1'b0;
    flush      = 1'b0;
    blk_ready  = 1'b0;
    up_q.delete();
    word_valid = 1'b0;
    rd_cnt     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic expect_block(input string name, input logic [127:0] exp, input int budget);
    int n;
    n = 0;
    blk_ready = 1'b1;
    while (!blk_valid && n < budget) begin
      step();
      n++;
    end
    check({name, "_valid"}, 128'(blk_valid), 128'(1));
    check(name, blk_out, exp);
    step();
    blk_ready = 1'b0;
  endtask

  initial begin
    int n;
    int nblk;
    int nchg;
    logic [1:0] prev_fc;

    resetn     = 1'b0;
    flush      = 1'b0;
    blk_ready  = 1'b0;
    word_valid = 1'b0;
    rd_cnt     = 0;
    #12;
    check("rst_word_rd", 128'(word_rd), 128'(0));
    check("rst_blk_valid", 128'(blk_valid), 128'(0));
    check("rst_blk_out", blk_out, 128'h0);
    check("rst_fill_cnt", 128'(fill_cnt), 128'(0));

    // Single block, cycle by cycle.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 128'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 128'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 128'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 128'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 128'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 128'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 128'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 128'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 128'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 128'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 128'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 128'h0F0E0D0C_0B0A0908_07060504_03020100};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 128'h0};

    apply_reset();
    push_block(0);
    for (int i = 0; i < 13; i++) begin
      blk_ready = tbl[i].ready;
      step();
      check($sformatf("tbl%0d_word_rd", i), 128'(word_rd), 128'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_blk_valid", i), 128'(blk_valid), 128'(tbl[i].exp_bv));
      check($sformatf("tbl%0d_fill_cnt", i), 128'(fill_cnt), 128'(tbl[i].exp_fc));
      if (tbl[i].chk_blk) check($sformatf("tbl%0d_blk_out", i), blk_out, tbl[i].exp_blk);
    end
    blk_ready = 1'b0;

    // Backpressure: third block must wait for a free slot.
    apply_reset();
    push_block(1);
    push_block(2);
    push_block(3);
    repeat (40) step();
    check("bp_rd_cnt8", 128'(rd_cnt), 128'(8));
    check("bp_valid", 128'(blk_valid), 128'(1));
    check("bp_blk_a", blk_out, mk_block(1));
    check("bp_word_valid_stuck", 128'(word_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_word_rd_held", 128'(word_rd), 128'(0));
    end
    check("bp_rd_cnt_still8", 128'(rd_cnt), 128'(8));
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    check("bp_after_drain_valid", 128'(blk_valid), 128'(1));
    check("bp_after_drain_blk_b", blk_out, mk_block(2));
    n = 0;
    while (rd_cnt == 8 && n < 10) begin
      step();
      n++;
    end
    check("bp_rd_resumed", 128'(rd_cnt), 128'(9));
    repeat (20) step();
    check("bp_rd_cnt12", 128'(rd_cnt), 128'(12));
    check("bp_fill_cnt0", 128'(fill_cnt), 128'(0));
    check("bp_word_valid_low", 128'(word_valid), 128'(0));
    expect_block("bp_blk_b", mk_block(2), 5);
    expect_block("bp_blk_c", mk_block(3), 5);
    check("bp_empty", 128'(blk_valid), 128'(0));

    // Stability: held block stays put while the partner fills.
    apply_reset();
    push_block(4);
    push_block(5);
    n = 0;
    while (!blk_valid && n < 30) begin
      step();
      n++;
    end
    check("st_valid", 128'(blk_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("st_hold%0d", i), blk_out, mk_block(4));
    end
    repeat (10) step();
    check("st_rd_cnt8", 128'(rd_cnt), 128'(8));
    expect_block("st_blk_a", mk_block(4), 2);
    expect_block("st_blk_b", mk_block(5), 2);
    check("st_empty", 128'(blk_valid), 128'(0));

    // Back-to-back drain with ready held high.
    apply_reset();
    blk_ready = 1'b1;
    for (int b = 6; b < 10; b++) push_block(b);
    prev_fc = 2'd0;
    nblk = 0;
    nchg = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (blk_valid) begin
        check($sformatf("b2b_blk%0d", nblk), blk_out, mk_block(6 + nblk));
        nblk++;
      end
      if (fill_cnt != prev_fc) begin
        check("b2b_fill_seq", 128'(fill_cnt), 128'(2'(prev_fc + 2'd1)));
        prev_fc = fill_cnt;
        nchg++;
      end
    end
    check("b2b_nblk", 128'(nblk), 128'(4));
    check("b2b_fill_changes", 128'(nchg), 128'(16));
    check("b2b_fill_end", 128'(fill_cnt), 128'(0));
    blk_ready = 1'b0;

    // Flush while capturing word 2 with a full block pending.
    apply_reset();
    push_block(10);
    for (int k = 0; k < 3; k++) push_word(mk_word(11, k));
    n = 0;
    while (!(blk_valid && fill_cnt == 2'd2) && n < 60) begin
      step();
      n++;
    end
    check("fl_pre_valid", 128'(blk_valid), 128'(1));
    step();
    check("fl_req", 128'(word_rd), 128'(1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_blk_valid", 128'(blk_valid), 128'(0));
    check("fl_fill_cnt", 128'(fill_cnt), 128'(0));
    check("fl_word_rd", 128'(word_rd), 128'(0));
    check("fl_word_taken", 128'(word_valid), 128'(0));
    repeat (3) step();
    push_block(12);
    expect_block("fl_clean", mk_block(12), 30);
    check("fl_clean_fill_cnt", 128'(fill_cnt), 128'(0));

    // Asynchronous reset in the middle of a request.
    apply_reset();
    push_block(13);
    push_word(mk_word(14, 0));
    push_word(mk_word(14, 1));
    n = 0;
    while (!(blk_valid && fill_cnt == 2'd1 && word_rd) && n < 60) begin
      step();
      n++;
    end
    check("ar_pre_valid", 128'(blk_valid), 128'(1));
    check("ar_pre_rd", 128'(word_rd), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("ar_word_rd", 128'(word_rd), 128'(0));
    check("ar_blk_valid", 128'(blk_valid), 128'(0));
    check("ar_blk_out", blk_out, 128'h0);
    check("ar_fill_cnt", 128'(fill_cnt), 128'(0));
    apply_reset();
    push_block(15);
    expect_block("ar_after", mk_block(15), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_blk_assembler.md
Name: aes_blk_assembler

Overview:
- Consumes 4-byte words from the upstream 1-to-4 byte collector and assembles them into 16-byte AES state blocks (4 words per block, column-major).
- Handshake with the collector uses its full flag and read-enable pulse.
- Assembled blocks go to the AES datapath over a valid/ready interface.
- Ping-pong double buffer, so the next block fills while the core still holds the previous one.

Parameters:
- NW, 4, words per block.
- NB, 4, bytes per word; block width = NW*NB bytes = 16.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear; discards all buffered and partial data
- word_valid  in  1  upstream has a full word (driven by collector's full flag)
- word_rd  out  1  one-cycle read pulse to upstream (drives collector's rd_en)
- word_in  in  NB x 8  upstream word; valid the cycle after word_rd is sampled
- blk_valid  out  1  block available
- blk_ready  in  1  downstream accepts block
- blk_out  out  (NW*NB) x 8  assembled block; byte index w*NB+b = word w, byte b
- fill_cnt  out  2  words already in the block being filled (0..3)

Behaviour:
- Reset values: word_rd=0, blk_valid=0, blk_out=0, fill_cnt=0. Both buffers cleared, both full flags 0, fill_sel=0, out_sel=0, FSM in F_IDLE.
- Reset mid-operation discards partial and complete blocks.
- Fill FSM states, all registered:
  - F_IDLE: if word_valid=1 and buf_full[fill_sel]=0, then word_rd<=1 and go to F_REQ; else stay.
  - F_REQ: word_rd<=0; go to F_CAP. Upstream samples rd_en at this edge, registers the word and drops its full flag.
  - F_CAP: write word_in into slot fill_cnt of buffer fill_sel, then go to F_IDLE.
    - If fill_cnt=NW-1: set buf_full[fill_sel]=1, fill_cnt<=0, toggle fill_sel.
    - Else fill_cnt<=fill_cnt+1.
- Handshake timing:
  - word_rd is high for exactly one cycle per word.
  - word_valid is never re-sampled before F_IDLE, so the upstream flag already reflects the read.
  - Maximum rate is 1 word per 3 cycles.
- Output side:
  - blk_valid = buf_full[out_sel]; blk_out = buffer[out_sel], mux from registered buffers.
  - On blk_valid&&blk_ready at an edge: buf_full[out_sel]<=0 and toggle out_sel.
  - blk_out must stay stable while blk_valid=1 and blk_ready=0.
- Latency: blk_valid is high in the cycle after the edge that captures word NW-1.
- Both buffers full: the FSM holds in F_IDLE, word_rd stays 0, and backpressure propagates upstream.
- Simultaneous events:
  - Completing the fill of one buffer and draining the other in the same cycle are independent; both take effect.
  - Draining the only full buffer while its partner becomes full on the same edge: out_sel toggles onto the newly full buffer, so blk_valid stays 1 with new data.
- flush, checked after reset and before everything else:
  - Clears both full flags, fill_cnt, fill_sel and out_sel; FSM goes to F_IDLE; word_rd<=0.
  - A word already handed over by upstream (flush in F_REQ or F_CAP) is dropped.
  - Buffer contents need not be zeroed, but blk_valid must be 0 the next cycle.
- fill_cnt wraps 3 to 0 only via block completion. It never exceeds NW-1.

Decomposition:
- Shared package aes_pkg:
  - typedefs byte_t [7:0], word_t [NB-1:0] byte_t, state_t [NW*NB-1:0] byte_t
  - localparams AES_NW=4, AES_NB=4
  - fill FSM enum {F_IDLE, F_REQ, F_CAP}
- One natural sub-module, aes_blk_slot, instantiated twice:
  - one 16-byte buffer with word-indexed write enable, full flag set/clear and sync clear.
- The top holds the FSM, fill/out selectors and output mux.

Test Plan:
- Single block: upstream presents words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with blk_ready=1.
  - Expect 4 word_rd pulses, each one cycle, spaced 3 cycles apart.
  - Expect blk_valid one cycle after the last capture, with blk_out bytes 0x00..0x0F in index order; blk_valid low the following cycle.
- Backpressure: blk_ready=0, feed 3 blocks.
  - Expect 2 blocks buffered, then word_rd held 0 and word_valid stuck high.
  - Then raise blk_ready for 1 cycle: 1 block drains, word_rd resumes, and the 3rd block fills.
- Stability: blk_valid=1, blk_ready=0 for 10 cycles while the other buffer fills. Expect blk_out unchanged; on blk_ready=1, blocks come out in order A then B.
- Back-to-back drain: blk_ready held at 1, 4 blocks streamed. Expect 4 blk_valid pulses with correct data and fill_cnt sequence 0,1,2,3,0 per block.
- Flush: assert flush in F_CAP of word 2 with one full buffer pending.
  - Expect blk_valid=0, fill_cnt=0, word_rd=0 the next cycle.
  - The next 4 words form a clean block.
- Async reset: pull resetn low mid-F_REQ. Expect all outputs 0 immediately, with no edge needed; normal operation after release.
